// File: rtl/line_buffer_sequencer.sv
// Sequences one projection line through the partitioned line buffer: fill with
// filtered samples, flush with zeros, and tag each tap word with a sample index.
module line_buffer_sequencer #(
    parameter int pNoTaps     = 4,
    parameter int pTapsWidth  = 8,
    parameter int pDataLength = 16,
    parameter int pLineLength = 256,
    parameter int pIndexWidth = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [pDataLength-1:0] in_data,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   lb_enable,
    output logic [pDataLength-1:0] lb_shift_in,
    output logic                   taps_valid,
    output logic [pIndexWidth-1:0] sample_index,
    output logic                   line_done,
    output logic                   busy
);

    localparam int kFlushLength     = (pNoTaps - 1) * pTapsWidth;
    localparam int kInCountWidth    = (pLineLength > 1) ? $clog2(pLineLength) : 1;
    localparam int kFlushCountWidth = (kFlushLength > 1) ? $clog2(kFlushLength) : 1;
    localparam logic [kInCountWidth-1:0]    kInLast    = kInCountWidth'(pLineLength - 1);
    localparam logic [kFlushCountWidth-1:0] kFlushLast =
        kFlushCountWidth'((kFlushLength > 0) ? kFlushLength - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH
    } state_t;

    state_t                      state_q, state_d;
    logic [kInCountWidth-1:0]    inCount_q, inCount_d;
    logic [kFlushCountWidth-1:0] flushCount_q, flushCount_d;
    logic [pIndexWidth-1:0]      sampleIndex_q, sampleIndex_d;
    logic                        tapsValid_q, tapsValid_d;
    logic                        lineDone_q, lineDone_d;

    // Every shift moves a new word to tap 0; its index is the shift count minus one.
    always_comb begin
        state_d       = state_q;
        inCount_d     = inCount_q;
        flushCount_d  = flushCount_q;
        sampleIndex_d = sampleIndex_q;
        lineDone_d    = 1'b0;

        in_ready    = (state_q == FILL) && out_ready;
        lb_enable   = ((state_q == FILL) && in_valid && out_ready) ||
                      ((state_q == FLUSH) && out_ready);
        lb_shift_in = (state_q == FILL) ? in_data : '0;
        busy        = (state_q != IDLE);
        tapsValid_d = lb_enable;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = FILL;
                    inCount_d    = '0;
                    flushCount_d = '0;
                end
            end
            FILL: begin
                if (lb_enable) begin
                    sampleIndex_d = pIndexWidth'(inCount_q);
                    inCount_d     = inCount_q + kInCountWidth'(1);
                    if (inCount_q == kInLast) begin
                        if (kFlushLength == 0) begin
                            state_d    = IDLE;
                            lineDone_d = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (lb_enable) begin
                    sampleIndex_d = pIndexWidth'(pLineLength) + pIndexWidth'(flushCount_q);
                    flushCount_d  = flushCount_q + kFlushCountWidth'(1);
                    if (flushCount_q == kFlushLast) begin
                        state_d    = IDLE;
                        lineDone_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            inCount_q     <= '0;
            flushCount_q  <= '0;
            sampleIndex_q <= '0;
            tapsValid_q   <= 1'b0;
            lineDone_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            inCount_q     <= inCount_d;
            flushCount_q  <= flushCount_d;
            sampleIndex_q <= sampleIndex_d;
            tapsValid_q   <= tapsValid_d;
            lineDone_q    <= lineDone_d;
        end
    end

    assign taps_valid   = tapsValid_q;
    assign sample_index = sampleIndex_q;
    assign line_done    = lineDone_q;

endmodule
